gpout_bank: RTL and testbench
=============================

GPOUT_BANK -- requirements
Module: gpout_bank

Interface
REQ-001 Parameter CHANNELS, default 6: number of general-purpose output channels.
REQ-002 Parameter SRC_W, default 64: number of external source bits selectable per channel.
REQ-003 Parameter SEL_W, default 7: select code width; SEL_W SHALL satisfy 2**SEL_W >= SRC_W+2.
REQ-004 Parameter DIV_W, default 8: clock-divider compare width.
REQ-005 i_clk  in  1  sole clock; all state on posedge.
REQ-006 i_reset_n  in  1  asynchronous, active-low reset.
REQ-007 i_src  in  SRC_W  source bits; may be asynchronous to i_clk (e.g. SPI pins).
REQ-008 i_sel  in  CHANNELS*SEL_W  per-channel select code; channel c uses bits [c*SEL_W +: SEL_W].
REQ-009 i_mode  in  CHANNELS*2  per-channel mode; channel c uses bits [2c +: 2].
REQ-010 i_load  in  1  strobe; captures i_sel and i_mode into shadow registers.
REQ-011 i_clear  in  CHANNELS  per-channel synchronous clear of the sticky and toggle state.
REQ-012 i_div  in  DIV_W  divider terminal count.
REQ-013 o_gpout  out  CHANNELS  channel outputs.
REQ-014 o_clkdiv  out  1  divided clock, registered.
REQ-015 o_busy  out  1  high while the post-load settle window is active.

Function
REQ-016 Per channel, the selected bit s SHALL be: i_src[code] for code < SRC_W; o_clkdiv for code == SRC_W; 0 for every other code.
REQ-017 Mode 00 (direct): o_gpout[c] = s, combinational, zero latency.
REQ-018 Mode 01 (registered): o_gpout[c] = s sampled at the previous posedge (1-cycle latency).
REQ-019 Modes 10 and 11 SHALL pass s through a 2-flop synchroniser (sy1, sy2) and then a history flop prev; rise = sy2 & ~prev & ~o_busy.
REQ-020 Mode 10 (sticky): the state bit SHALL set on rise and hold until i_clear[c]; o_gpout[c] = state.
REQ-021 Mode 11 (toggle): the state bit SHALL invert on each rise; o_gpout[c] = state.
REQ-022 If s is sampled high at posedge k with prev low, modes 10/11 SHALL update o_gpout after posedge k+2.
REQ-023 i_clear[c] asserted in the same cycle as a rise SHALL win; the state bit is 0 after that edge.
REQ-024 The synchroniser and prev flops SHALL run in every mode, so a later mode change sees a valid history.
REQ-025 On i_load, all channel shadows SHALL update at that posedge; the new selection takes effect in the following cycle.
REQ-026 On i_load, a 2-bit settle counter SHALL load 3 and decrement each cycle to 0; o_busy = (settle != 0).
REQ-027 While o_busy is high, rise SHALL be suppressed in every channel; state bits are not altered by i_load itself.
REQ-028 i_load while o_busy is high SHALL recapture the shadows and reload settle to 3.
REQ-029 Divider: count runs 0..i_div and wraps to 0; o_clkdiv toggles at each wrap; period = 2*(i_div+1) cycles; i_div==0 gives clk/2.
REQ-030 If count > i_div (i_div lowered at run time), the next cycle SHALL wrap count to 0 and toggle o_clkdiv.
REQ-031 Codes SRC_W+1 up to 2**SEL_W-1 SHALL output constant 0 in every mode (modes 10/11: no rise).

Reset
REQ-032 While i_reset_n is low: every sel shadow = 0, every mode shadow = 00, all sync/prev/state/registered flops = 0, count = 0, o_clkdiv = 0, settle = 0, o_busy = 0.
REQ-033 After reset, o_gpout[c] = i_src[0] (direct mode); reset assertion mid-operation SHALL clear all state immediately, without waiting for a clock.

Verification
REQ-034 Reset, then i_src[0]=1 -> every o_gpout bit = 1 with no clock edge; o_clkdiv = 0; o_busy = 0.
REQ-035 CHANNELS=6, load ch2 sel=5 mode=01, pulse i_src[5] high for 1 cycle -> o_gpout[2] high for exactly 1 cycle, 1 cycle late.
REQ-036 Load ch0 sel=7 mode=10 with i_src[7] already high -> o_busy high 3 cycles, no false set; drop, then raise i_src[7] -> o_gpout[0] set 2 edges later; i_clear[0] -> 0.
REQ-037 Mode 11, 4 rising edges on the source -> o_gpout toggles 4 times and ends at 0; clear coincident with a rise -> 0.
REQ-038 i_div=0 -> o_clkdiv period 2 cycles; i_div=3 -> period 8; change i_div 200->10 while count=150 -> wrap and toggle on the next cycle.
REQ-039 Select code 64 (=SRC_W) on ch5, mode 00 -> o_gpout[5] mirrors o_clkdiv; code 100 -> constant 0.

Source files
------------

// File: rtl/gpout_bank.sv
`default_nettype none
// ============================================================================
//  Module   : gpout_bank
//  Purpose  : Bank of general-purpose outputs. Each channel selects one
//             external source bit (or the divided clock, or constant 0) and
//             presents it directly, registered, as a sticky edge flag, or as
//             an edge-driven toggle. Includes a programmable clock divider and
//             a post-load settle window that masks spurious edges.
//  Revision : 1.0 - initial release
// ============================================================================
module gpout_bank #(
  parameter int CHANNELS = 6,
  parameter int SRC_W    = 64,
  parameter int SEL_W    = 7,
  parameter int DIV_W    = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [SRC_W-1:0]          i_src,
  input  logic [CHANNELS*SEL_W-1:0] i_sel,
  input  logic [CHANNELS*2-1:0]     i_mode,
  input  logic                      i_load,
  input  logic [CHANNELS-1:0]       i_clear,
  input  logic [DIV_W-1:0]          i_div,
  output logic [CHANNELS-1:0]       o_gpout,
  output logic                      o_clkdiv,
  output logic                      o_busy
);

  localparam logic [1:0]       MODE_DIRECT = 2'b00;
  localparam logic [1:0]       MODE_REG    = 2'b01;
  localparam logic [1:0]       MODE_STICKY = 2'b10;
  localparam logic [1:0]       SETTLE_INIT = 2'd3;
  localparam logic [SEL_W-1:0] CODE_CLKDIV = SEL_W'(SRC_W);

  logic [CHANNELS*SEL_W-1:0] sel_q, sel_d;
  logic [CHANNELS*2-1:0]     mode_q, mode_d;
  logic [1:0]                settle_q, settle_d;
  logic [DIV_W-1:0]          count_q, count_d;
  logic                      clkdiv_q, clkdiv_d;
  logic                      busy;

  assign busy     = (settle_q != 2'd0);
  assign o_busy   = busy;
  assign o_clkdiv = clkdiv_q;

  // Shadow capture, settle countdown and divider next-state
  always_comb begin
    sel_d    = sel_q;
    mode_d   = mode_q;
    settle_d = settle_q;
    count_d  = count_q;
    clkdiv_d = clkdiv_q;
    if (i_load) begin
      sel_d    = i_sel;
      mode_d   = i_mode;
      settle_d = SETTLE_INIT;
    end else if (busy) begin
      settle_d = settle_q - 2'd1;
    end
    // ">=" also catches a count stranded above a freshly lowered terminal
    if (count_q >= i_div) begin
      count_d  = '0;
      clkdiv_d = ~clkdiv_q;
    end else begin
      count_d  = count_q + DIV_W'(1);
    end
  end

  // Shared state registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sel_q    <= '0;
      mode_q   <= '0;
      settle_q <= '0;
      count_q  <= '0;
      clkdiv_q <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      mode_q   <= mode_d;
      settle_q <= settle_d;
      count_q  <= count_d;
      clkdiv_q <= clkdiv_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SEL_W-1:0] code;
    logic [1:0]       mode;
    logic             sel_bit;
    logic             rise;
    logic             out_bit;
    logic             sy1_q, sy2_q, prev_q, state_q, reg_q;
    logic             state_d;

    assign code = sel_q[c*SEL_W +: SEL_W];
    assign mode = mode_q[c*2 +: 2];
    assign rise = sy2_q & ~prev_q & ~busy;

    // Source select: external bit, divided clock, or 0 for unused codes
    always_comb begin
      sel_bit = 1'b0;
      for (int b = 0; b < SRC_W; b++) begin
        if (code == SEL_W'(b)) sel_bit = i_src[b];
      end
      if (code == CODE_CLKDIV) sel_bit = clkdiv_q;
    end

    // Sticky/toggle state update; a clear beats a simultaneous rise
    always_comb begin
      state_d = state_q;
      if (i_clear[c]) begin
        state_d = 1'b0;
      end else if (rise && mode[1]) begin
        state_d = (mode == MODE_STICKY) ? 1'b1 : ~state_q;
      end
    end

    // Synchroniser and history run in every mode so a mode switch sees valid history
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        sy1_q   <= 1'b0;
        sy2_q   <= 1'b0;
        prev_q  <= 1'b0;
        state_q <= 1'b0;
        reg_q   <= 1'b0;
      end else begin
        sy1_q   <= sel_bit;
        sy2_q   <= sy1_q;
        prev_q  <= sy2_q;
        state_q <= state_d;
        reg_q   <= sel_bit;
      end
    end

    // Output mux per mode
    always_comb begin
      case (mode)
        MODE_DIRECT: out_bit = sel_bit;
        MODE_REG:    out_bit = reg_q;
        default:     out_bit = state_q;
      endcase
    end

    assign o_gpout[c] = out_bit;
  end

endmodule
`default_nettype wire

// File: tb/tb_gpout_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpout_bank
//  Purpose  : Directed self-checking bench for gpout_bank.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpout_bank;
  localparam int CH    = 6;
  localparam int SRC_W = 64;
  localparam int SEL_W = 7;
  localparam int DIV_W = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [SRC_W-1:0]       i_src;
  logic [CH*SEL_W-1:0]    i_sel;
  logic [CH*2-1:0]        i_mode;
  logic                   i_load;
  logic [CH-1:0]          i_clear;
  logic [DIV_W-1:0]       i_div;
  logic [CH-1:0]          o_gpout;
  logic                   o_clkdiv;
  logic                   o_busy;

  logic [CH*SEL_W-1:0]    sel_v;
  logic [CH*2-1:0]        mode_v;
  logic                   exp_clk;
  int                     checks = 0;
  int                     errors = 0;

  gpout_bank #(.CHANNELS(CH), .SRC_W(SRC_W), .SEL_W(SEL_W), .DIV_W(DIV_W)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_src     (i_src),
    .i_sel     (i_sel),
    .i_mode    (i_mode),
    .i_load    (i_load),
    .i_clear   (i_clear),
    .i_div     (i_div),
    .o_gpout   (o_gpout),
    .o_clkdiv  (o_clkdiv),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input int sel, input logic [1:0] mode);
    sel_v[ch*SEL_W +: SEL_W] = SEL_W'(sel);
    mode_v[ch*2 +: 2]        = mode;
    i_sel  = sel_v;
    i_mode = mode_v;
    i_load = 1'b1;
    tick();
    i_load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_src = '0; i_sel = '0; i_mode = '0; i_load = 1'b0;
    i_clear = '0; i_div = 8'd200; sel_v = '0; mode_v = '0;
    #12;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    checks++; if (o_clkdiv !== 1'b0) begin errors++; $display("FAIL reset_clkdiv: got %b expected 0", o_clkdiv); end
    checks++; if (o_gpout !== 6'h00) begin errors++; $display("FAIL reset_gpout: got %h expected 00", o_gpout); end
    i_src[0] = 1'b1;
    #1;
    checks++; if (o_gpout !== 6'h3f) begin errors++; $display("FAIL reset_direct_src0: got %h expected 3f", o_gpout); end
    rst_n = 1'b1;
    #1;
    checks++; if (o_gpout !== 6'h3f) begin errors++; $display("FAIL post_reset_direct: got %h expected 3f", o_gpout); end
    checks++; if (o_clkdiv !== 1'b0) begin errors++; $display("FAIL post_reset_clkdiv: got %b expected 0", o_clkdiv); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", o_busy); end
    i_src = '0;
    tick();
  endtask

  task automatic test_registered();
    load(2, 5, 2'b01);
    tick(); tick();
    i_src[5] = 1'b1;
    #1;
    checks++; if (o_gpout[2] !== 1'b0) begin errors++; $display("FAIL reg_not_early: got %b expected 0", o_gpout[2]); end
    tick();
    checks++; if (o_gpout[2] !== 1'b1) begin errors++; $display("FAIL reg_one_late: got %b expected 1", o_gpout[2]); end
    i_src[5] = 1'b0;
    tick();
    checks++; if (o_gpout[2] !== 1'b0) begin errors++; $display("FAIL reg_one_cycle: got %b expected 0", o_gpout[2]); end
  endtask

  task automatic test_sticky();
    i_src[7] = 1'b1;
    tick(); tick();
    load(0, 7, 2'b10);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_after_load: got %b expected 1", o_busy); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (o_busy !== (i < 3)) begin errors++; $display("FAIL busy_window_%0d: got %b expected %b", i, o_busy, (i < 3)); end
    end
    tick(); tick();
    checks++; if (o_gpout[0] !== 1'b0) begin errors++; $display("FAIL sticky_no_false_set: got %b expected 0", o_gpout[0]); end
    i_src[7] = 1'b0;
    tick(); tick(); tick();
    i_src[7] = 1'b1;
    tick();
    checks++; if (o_gpout[0] !== 1'b0) begin errors++; $display("FAIL sticky_k: got %b expected 0", o_gpout[0]); end
    tick();
    checks++; if (o_gpout[0] !== 1'b0) begin errors++; $display("FAIL sticky_k1: got %b expected 0", o_gpout[0]); end
    tick();
    checks++; if (o_gpout[0] !== 1'b1) begin errors++; $display("FAIL sticky_k2_set: got %b expected 1", o_gpout[0]); end
    tick();
    checks++; if (o_gpout[0] !== 1'b1) begin errors++; $display("FAIL sticky_hold: got %b expected 1", o_gpout[0]); end
    i_clear[0] = 1'b1;
    tick();
    i_clear[0] = 1'b0;
    checks++; if (o_gpout[0] !== 1'b0) begin errors++; $display("FAIL sticky_clear: got %b expected 0", o_gpout[0]); end
    tick();
    checks++; if (o_gpout[0] !== 1'b0) begin errors++; $display("FAIL sticky_stays_clear: got %b expected 0", o_gpout[0]); end
  endtask

  task automatic test_toggle();
    logic exp_t;
    exp_t = 1'b0;
    i_src[8] = 1'b0;
    load(1, 8, 2'b11);
    repeat (4) tick();
    for (int p = 0; p < 4; p++) begin
      i_src[8] = 1'b1;
      tick(); tick();
      i_src[8] = 1'b0;
      tick(); tick();
      exp_t = ~exp_t;
      checks++;
      if (o_gpout[1] !== exp_t) begin errors++; $display("FAIL toggle_%0d: got %b expected %b", p, o_gpout[1], exp_t); end
    end
    i_src[8] = 1'b1;
    tick(); tick();
    i_clear[1] = 1'b1;
    tick();
    i_clear[1] = 1'b0;
    checks++; if (o_gpout[1] !== 1'b0) begin errors++; $display("FAIL toggle_clear_wins: got %b expected 0", o_gpout[1]); end
    i_src[8] = 1'b0;
    tick(); tick(); tick();
    checks++; if (o_gpout[1] !== 1'b0) begin errors++; $display("FAIL toggle_after_clear: got %b expected 0", o_gpout[1]); end
  endtask

  task automatic test_divider();
    // count is far below 200 so far, hence the divided clock is still 0
    i_div = 8'd0;
    tick();
    exp_clk = 1'b1;
    checks++; if (o_clkdiv !== exp_clk) begin errors++; $display("FAIL div0_first: got %b expected %b", o_clkdiv, exp_clk); end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_clk = ~exp_clk;
      checks++;
      if (o_clkdiv !== exp_clk) begin errors++; $display("FAIL div0_edge%0d: got %b expected %b", i, o_clkdiv, exp_clk); end
    end
    i_div = 8'd3;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n % 4 == 0) exp_clk = ~exp_clk;
      checks++;
      if (o_clkdiv !== exp_clk) begin errors++; $display("FAIL div3_edge%0d: got %b expected %b", n, o_clkdiv, exp_clk); end
    end
    i_div = 8'd200;
    repeat (150) tick();
    checks++; if (o_clkdiv !== exp_clk) begin errors++; $display("FAIL div200_hold: got %b expected %b", o_clkdiv, exp_clk); end
    i_div = 8'd10;
    tick();
    exp_clk = ~exp_clk;
    checks++; if (o_clkdiv !== exp_clk) begin errors++; $display("FAIL div_lower_wrap: got %b expected %b", o_clkdiv, exp_clk); end
    repeat (10) tick();
    checks++; if (o_clkdiv !== exp_clk) begin errors++; $display("FAIL div10_hold: got %b expected %b", o_clkdiv, exp_clk); end
    tick();
    exp_clk = ~exp_clk;
    checks++; if (o_clkdiv !== exp_clk) begin errors++; $display("FAIL div10_wrap: got %b expected %b", o_clkdiv, exp_clk); end
  endtask

  task automatic test_async_reset_and_select();
    i_src[7] = 1'b0;
    repeat (3) tick();
    i_src[7] = 1'b1;
    repeat (3) tick();
    checks++; if (o_gpout[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_sticky: got %b expected 1", o_gpout[0]); end
    i_src[0] = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (o_gpout !== 6'h3f) begin errors++; $display("FAIL async_reset_gpout: got %h expected 3f", o_gpout); end
    checks++; if (o_clkdiv !== 1'b0) begin errors++; $display("FAIL async_reset_clkdiv: got %b expected 0", o_clkdiv); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b expected 0", o_busy); end
    rst_n = 1'b1;
    sel_v = '0; mode_v = '0; i_src = '0; i_div = 8'd0;
    exp_clk = 1'b0;
    tick();
    exp_clk = ~exp_clk;
    load(5, 64, 2'b00);
    exp_clk = ~exp_clk;
    checks++; if (o_gpout[5] !== exp_clk) begin errors++; $display("FAIL sel_clkdiv_0: got %b expected %b", o_gpout[5], exp_clk); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_clk = ~exp_clk;
      checks++;
      if (o_gpout[5] !== exp_clk) begin errors++; $display("FAIL sel_clkdiv_%0d: got %b expected %b", i, o_gpout[5], exp_clk); end
    end
    load(5, 100, 2'b00);
    i_src = '1;
    #1;
    checks++; if (o_gpout[5] !== 1'b0) begin errors++; $display("FAIL sel_unused_direct: got %b expected 0", o_gpout[5]); end
    checks++; if (o_gpout[4] !== 1'b1) begin errors++; $display("FAIL sel_neighbour_direct: got %b expected 1", o_gpout[4]); end
    load(5, 100, 2'b01);
    tick();
    checks++; if (o_gpout[5] !== 1'b0) begin errors++; $display("FAIL sel_unused_reg: got %b expected 0", o_gpout[5]); end
  endtask

  initial begin
    test_reset();
    test_registered();
    test_sticky();
    test_toggle();
    test_divider();
    test_async_reset_and_select();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
